// File: rtl/apb_regbank_ctrl.sv
// apb_regbank_ctrl: APB3 register bank with start/done control and a registered core read port
module apb_regbank_ctrl #(
  parameter int AMBA_WORD       = 16,
  parameter int AMBA_ADDR_DEPTH = 20,
  parameter int REG_DEPTH       = 4096,
  parameter int WHITE_DEFAULT   = 255
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       psel,
  input  logic                       penable,
  input  logic                       pwrite,
  input  logic [AMBA_ADDR_DEPTH-1:0] paddr,
  input  logic [AMBA_WORD-1:0]       pwdata,
  output logic [AMBA_WORD-1:0]       prdata,
  output logic                       pready,
  output logic                       pslverr,
  input  logic                       core_rd_en,
  input  logic [AMBA_ADDR_DEPTH-1:0] core_addr,
  output logic [AMBA_WORD-1:0]       core_rdata,
  input  logic                       core_done,
  output logic                       start,
  output logic                       done
);
  localparam int AW = AMBA_ADDR_DEPTH;
  localparam int IW = $clog2(REG_DEPTH);
  typedef enum logic [1:0] {IDLE, ACCESS, RDRESP} state_t;
  state_t state;
  logic [AW-1:0] a_addr;
  logic [AMBA_WORD-1:0] a_wdata;
  logic a_write, a_err, wr_ok;
  logic [AMBA_WORD-1:0] cfg [10];
  logic [AMBA_WORD-1:0] mem [REG_DEPTH];
  // One extra bit so REG_DEPTH == 2**AW still compares correctly
  function automatic logic in_range(input logic [AW-1:0] a);
    return {1'b0, a} < (AW+1)'(REG_DEPTH);
  endfunction
  function automatic logic [AMBA_WORD-1:0] rd(input logic [AW-1:0] a);
    return !in_range(a) ? '0 : a == '0 ? AMBA_WORD'({done, start}) :
           a < AW'(10) ? cfg[a[3:0]] : mem[a[IW-1:0]];
  endfunction
  assign wr_ok = state == ACCESS && a_write && !a_err;
  // Pixel words carry no reset
  always_ff @(posedge clk)
    if (wr_ok && a_addr >= AW'(10)) mem[a_addr[IW-1:0]] <= a_wdata;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      prdata     <= '0;
      pready     <= 1'b0;
      pslverr    <= 1'b0;
      core_rdata <= '0;
      start      <= 1'b0;
      done       <= 1'b0;
      a_addr     <= '0;
      a_wdata    <= '0;
      a_write    <= 1'b0;
      a_err      <= 1'b0;
      cfg[0]     <= '0;
      cfg[1]     <= AMBA_WORD'(WHITE_DEFAULT);
      for (int i = 2; i < 10; i++) cfg[i] <= '0;
    end else begin
      pready  <= 1'b0;
      pslverr <= 1'b0;
      if (core_rd_en) core_rdata <= rd(core_addr);
      if (wr_ok && a_addr != '0 && a_addr < AW'(10)) cfg[a_addr[3:0]] <= a_wdata;
      // Completion from the core takes priority over a concurrent CTRL write
      if (core_done && start) begin
        start <= 1'b0;
        done  <= 1'b1;
      end else if (wr_ok && a_addr == '0) begin
        if (a_wdata[0] && !start) begin
          start <= 1'b1;
          done  <= 1'b0;
        end else if (!a_wdata[0]) start <= 1'b0;
      end
      case (state)
        IDLE: if (psel && !penable) begin
          a_addr  <= paddr;
          a_write <= pwrite;
          a_wdata <= pwdata;
          a_err   <= !in_range(paddr) || (pwrite && start && paddr != '0);
          state   <= ACCESS;
        end
        ACCESS: begin
          pready  <= a_err || a_write;
          pslverr <= a_err;
          if (a_err) prdata <= '0;
          state   <= (a_err || a_write) ? IDLE : RDRESP;
        end
        RDRESP: begin
          pready <= 1'b1;
          prdata <= rd(a_addr);
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
